// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller in front of an external dual-port RAM with a 1-cycle registered read.
// Latency: push -> out_valid two edges later; in_ready falls when the RAM is full; an out reg + skid absorb the read latency.
module ram_fifo_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 5,
  parameter int A_MAX   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic [A_WIDTH+1:0] count,
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               write_enable,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read
);

  localparam logic [A_WIDTH-1:0] LAST_PTR = A_WIDTH'(A_MAX - 1);
  localparam logic [A_WIDTH:0]   MAX_CNT  = (A_WIDTH + 1)'(A_MAX);

  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic               pending_q, pending_d;
  logic [1:0]         out_occ_q, out_occ_d;
  logic [D_WIDTH-1:0] out_q, out_d;
  logic [D_WIDTH-1:0] skid_q, skid_d;
  logic               in_rdy_q, in_rdy_d;

  logic               push, pop, issue;
  logic [2:0]         occ_sum;
  logic [1:0]         occ_after_pop;

  function automatic logic [A_WIDTH-1:0] next_ptr(input logic [A_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready      = in_rdy_q;
  assign out_valid     = (out_occ_q != 2'd0);
  assign out_data      = out_q;
  assign push          = in_valid & in_rdy_q;
  assign pop           = out_valid & out_ready;
  assign write_enable  = push;
  assign address_write = wr_ptr_q;
  assign data_write    = in_data;
  assign address_read  = rd_ptr_q;
  assign count         = (A_WIDTH + 2)'(ram_cnt_q) + (A_WIDTH + 2)'(pending_q)
                       + (A_WIDTH + 2)'(out_occ_q);

  // Only fetch when the word in flight is guaranteed a slot in out reg or skid.
  assign occ_sum       = ({1'b0, out_occ_q} + {2'b0, pending_q}) - {2'b0, pop};
  assign issue         = (ram_cnt_q != '0) && (occ_sum < 3'd2);
  assign occ_after_pop = out_occ_q - {1'b0, pop};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    out_d     = out_q;
    skid_d    = skid_q;
    out_occ_d = occ_after_pop;
    pending_d = issue;

    if (push)  wr_ptr_d = next_ptr(wr_ptr_q);
    if (issue) rd_ptr_d = next_ptr(rd_ptr_q);

    case ({push, issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
    in_rdy_d = (ram_cnt_d < MAX_CNT);

    if (pop && out_occ_q == 2'd2) out_d = skid_q;
    if (pending_q) begin
      if (occ_after_pop == 2'd0) out_d  = data_read;
      else                       skid_d = data_read;
      out_occ_d = occ_after_pop + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      pending_q <= 1'b0;
      out_occ_q <= 2'd0;
      out_q     <= '0;
      skid_q    <= '0;
      in_rdy_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      pending_q <= pending_d;
      out_occ_q <= out_occ_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      in_rdy_q  <= in_rdy_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue-based reference FIFO and a negedge monitor.
module tb_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int AM = 32;
  localparam int CAP = AM + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, write_enable;
  logic [DW-1:0] in_data, out_data, data_write, data_read;
  logic [AW+1:0] count;
  logic [AW-1:0] address_write, address_read;

  logic [DW-1:0] mem [0:AM-1];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] next_dat;
  logic [DW-1:0] last_pop;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_pops   = 0;
  int            n_pushes = 0;

  ram_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .address_write(address_write), .data_write(data_write), .write_enable(write_enable),
    .address_read(address_read), .data_read(data_read)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with a registered read port, contents untouched by reset.
  always @(posedge clk) begin
    if (write_enable) mem[address_write] <= data_write;
    data_read <= mem[address_read];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endfunction

  // Reference model: words held = queue contents; handshakes are predicted for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("count_cap", 32'(count > CAP), 0);
      chk("wen", 32'(write_enable), 32'(in_valid && in_ready));
      if (write_enable) chk("wdata", 32'(data_write), 32'(in_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_empty: got %0h, expected no word", out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          last_pop = out_data;
          n_pops++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        n_pushes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    bit r = 1'b0;
    for (int i = 0; i < 20 && !r; i++) begin
      @(negedge clk);
      r = in_ready;
      tick();
    end
    if (!r) fail_now("wait_ready");
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    bit acc = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) fail_now("push_one");
  endtask

  task automatic stream(input int n, input int p_in, input int p_out, input bit rnd);
    int pushed = 0;
    int cyc = 0;
    bit acc;
    in_data = rnd ? DW'($urandom) : next_dat;
    while (pushed < n && cyc < n * 20 + 200) begin
      in_valid  = (int'($urandom_range(99)) < p_in);
      out_ready = (int'($urandom_range(99)) < p_out);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        pushed++;
        next_dat = next_dat + 1'b1;
        in_data  = rnd ? DW'($urandom) : next_dat;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (pushed < n) fail_now("stream");
  endtask

  task automatic drain();
    bit d = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && !d; i++) begin
      @(negedge clk);
      d = (count == 0) && !out_valid;
      tick();
    end
    out_ready = 1'b0;
    if (!d) fail_now("drain");
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, q0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; next_dat = '0; last_pop = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    wait_rdy();

    // Single word: visible two edges after the push edge.
    push_one(8'hC5);
    @(negedge clk); chk("lat_n1", 32'(out_valid), 0);
    @(negedge clk); chk("lat_n2", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h0C5);
    chk("lat_count", 32'(count), 1);
    tick();
    drain();

    // Fill to total capacity with out_ready low, then try to overfill.
    next_dat = 8'h00;
    stream(CAP, 100, 0, 1'b0);
    @(negedge clk);
    chk("full_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), CAP);
    tick();
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_hold", 32'(count), CAP);
    tick();
    drain();

    // Continuous streaming through pointer wrap.
    next_dat = 8'h00;
    p0 = n_pops; q0 = n_pushes;
    stream(100, 100, 100, 1'b0);
    @(negedge clk);
    chk("thru_pushes", 32'(n_pushes - q0), 100);
    chk("thru_pops", 32'(n_pops - p0), 97);
    chk("thru_count", 32'(count), 3);
    tick();
    drain();

    // Random handshakes with random data.
    stream(2000, 50, 50, 1'b1);
    drain();

    // Reset while partially full.
    stream(20, 100, 0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    tick(); tick();
    rst_n = 1'b1;
    p0 = n_pops;
    wait_rdy();
    push_one(8'h3A);
    drain();
    chk("post_rst_pops", 32'(n_pops - p0), 1);
    chk("post_rst_word", 32'(last_pop), 32'h03A);

    // Full FIFO, one pop with in_valid held: freed slot is refilled.
    stream(CAP, 100, 0, 1'b1);
    in_valid = 1'b1; in_data = 8'h5B; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("refill_ready", 32'(in_ready), 1);
    chk("refill_count33", 32'(count), CAP - 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("refill_count34", 32'(count), CAP);
    chk("refill_full", 32'(in_ready), 0);
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
